nonce_search_ctrl: RTL and testbench
====================================

# nonce_search_ctrl

Sequences a nonce search across the processor array. It issues one round per cycle to the NUMPROCESSORS hash processors: a base nonce, with each processor hashing base + its index. It tracks rounds in flight through the fixed-latency hash pipeline and picks the lowest-index successful processor. It then reports the winning nonce, or reports that the nonce space is exhausted. It sits between the block-header loader (start/abort) and the processor array, and replaces free-running nonce counting with an explicit search FSM.

## Interface
Parameters:
- NUMPROCESSORS, default 10: processors per round; base nonce step.
- NONCESPACE, default 1024: nonces searched are 0 .. NONCESPACE-1; legal range 1 .. 2^32.
- LATENCY, default 4: cycles from round issue to its success vector; must be ≥ 1.
- PARTITIONBITS, default $clog2(NUMPROCESSORS): processor index width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start_i  in  1  new header loaded; begin search at nonce 0.
- abort_i  in  1  discard current search.
- proc_ready_i  in  1  array accepts a round this cycle.
- success_i  in  NUMPROCESSORS  per-processor hit; bit i refers to the round issued LATENCY cycles earlier.
- round_valid_o  out  1  round issued this cycle.
- round_first_o  out  1  first round of the search; drives processor newblock.
- round_base_o  out  32  base nonce of the issued round.
- busy_o  out  1  state is RUN or DRAIN.
- done_o  out  1  search finished; held until start_i, abort_i or rst.
- found_o  out  1  done with a hit; valid while done_o is high.
- nonce_o  out  32  winning nonce; valid while found_o is high.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start_i, go to RUN.
  - Base counter is 0; round_first_o is pending.
- RUN:
  - round_valid_o = proc_ready_i (combinational).
  - On issue, base advances by NUMPROCESSORS, and round_first_o clears after the first issue.
  - Stalls (proc_ready_i low) leave the base unchanged, so there are no gaps and no duplicates.
  - The last round is the one with base + NUMPROCESSORS ≥ NONCESPACE. After issuing it, go to DRAIN.
- Tag pipe:
  - LATENCY-deep shift of {valid, base}, advancing every cycle; stalls insert bubbles.
  - At the output stage, if the tag is valid, mask bit i when base + i ≥ NONCESPACE. The comparison is 33-bit so it does not overflow.
  - If any unmasked bit is set, take the lowest index i, latch nonce_o = base + i, set found_o, and go to DONE.
- DRAIN:
  - No issue.
  - When the tag pipe is empty with no hit, go to DONE with found_o = 0.
- DONE:
  - Outputs held; in-flight results are ignored.
- start_i in RUN, DRAIN or DONE: flush the tag pipe, reset base to 0, go to RUN.
- abort_i in any state: flush the tag pipe, clear done_o, found_o and nonce_o, go to IDLE.
- Simultaneous events:
  - abort_i beats start_i.
  - A hit beats last-issue and DRAIN-empty transitions.
  - A hit in the same cycle as start_i is discarded; the restart wins.
- success_i is ignored whenever the output-stage tag is invalid.

## Timing
- Reset:
  - State IDLE and tag pipe cleared.
  - round_valid_o, round_first_o, busy_o, done_o and found_o are 0.
  - round_base_o and nonce_o are 0.
- start_i at cycle t: first issue can occur at t+1, with round_first_o = 1 and base 0.
- Round issued at cycle c: its success_i is sampled at c+LATENCY. On a hit, done_o, found_o and nonce_o are registered and high at c+LATENCY+1.
- Exhaustion: done_o rises at L+LATENCY+1, where L is the last issue cycle.
- busy_o, done_o, found_o and nonce_o are registered. round_valid_o is combinational from state and proc_ready_i.

## Configuration
- SEARCH_STATS_EN defined:
  - Adds output rounds_o [31:0], counting issued rounds since the last start_i.
  - Cleared by rst, start_i and abort_i; frozen in DONE.
- SEARCH_STATS_EN undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Package miner_pkg:
  - nonce_t (logic [31:0]).
  - search_state_t enum {IDLE, RUN, DRAIN, DONE}.
  - round_tag_t struct {valid, nonce_t base}.
- Sub-module lowest_set_encoder #(N): returns the index of the lowest set bit plus an any flag. It is purely combinational and reusable by other arbiters.

## Test plan
Default parameters for all scenarios: NUMPROCESSORS=10, NONCESPACE=100, LATENCY=4.
- Reset:
  - Stimulus: assert rst for 2 cycles with start_i high.
  - Response: all outputs 0 and no issue.
- Exhaustion:
  - Stimulus: start_i at cycle 0, proc_ready_i=1, no hits.
  - Response: bases 0,10,…,90 issued on cycles 1–10; done_o=1 and found_o=0 at cycle 15.
- Priority:
  - Stimulus: success_i bits 3 and 7 on the result of base 20.
  - Response: nonce_o=23 and found_o=1; later hits are ignored.
- Final-round mask (NONCESPACE=95):
  - Stimulus: bit 6 on base 90.
  - Response: ignored, found_o=0.
  - Stimulus: bit 4 on base 90.
  - Response: nonce_o=94.
- Backpressure:
  - Stimulus: proc_ready_i low for 3 cycles after base 30.
  - Response: next issued base is 40, with no duplicates; results are still aligned to their bases.
- Abort/restart:
  - Stimulus: abort_i at base 50, then start_i. A stale hit arrives on an old in-flight round.
  - Response: the stale hit is ignored; the new search restarts at base 0 with round_first_o=1.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared types for the nonce search controller and the processor-array glue.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package miner_pkg;

  typedef logic [31:0] nonce_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } search_state_t;

  // One slot of the in-flight tracker: which base nonce a hash round carries.
  typedef struct packed {
    logic   valid;
    nonce_t base;
  } round_tag_t;

endpackage

// File: rtl/lowest_set_encoder.sv
// Priority encoder: index of the lowest set request bit plus an any-set flag.
// Latency: purely combinational.
// Backpressure: none; output follows req directly.
module lowest_set_encoder #(
  parameter int unsigned N = 8,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan downward so the last assignment made is the lowest set bit.
  always_comb begin
    idx = '0;
    any = |req;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/nonce_search_ctrl.sv
// Nonce search FSM: one round per cycle to the hash array, lowest-index hit wins; SEARCH_STATS_EN adds rounds_o.
// Latency: result registered LATENCY+1 cycles after the winning (or last) round issues.
// Backpressure: proc_ready_i low stalls issue without skipping bases; the tag pipe fills with bubbles.
module nonce_search_ctrl
  import miner_pkg::*;
#(
  parameter int unsigned     NUMPROCESSORS = 10,
  parameter longint unsigned NONCESPACE    = 1024,
  parameter int unsigned     LATENCY       = 4,
  parameter int unsigned     PARTITIONBITS = (NUMPROCESSORS > 1) ? $clog2(NUMPROCESSORS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic                     proc_ready_i,
  input  logic [NUMPROCESSORS-1:0] success_i,
  output logic                     round_valid_o,
  output logic                     round_first_o,
  output logic [31:0]              round_base_o,
  output logic                     busy_o,
  output logic                     done_o,
`ifdef SEARCH_STATS_EN
  output logic [31:0]              rounds_o,
`endif
  output logic                     found_o,
  output logic [31:0]              nonce_o
);

  localparam logic [32:0] SPACE = 33'(NONCESPACE);
  localparam nonce_t      STEP  = 32'(NUMPROCESSORS);

  search_state_t state_q, state_d;

  nonce_t     base_q;
  logic       first_q;
  logic       found_q;
  nonce_t     nonce_q;
  round_tag_t tags_q [LATENCY];
  round_tag_t out_tag;

  logic                     issue;
  logic                     last_round;
  logic                     inflight;
  logic                     flush;
  logic                     take_hit;
  logic [NUMPROCESSORS-1:0] live_hits;
  logic [PARTITIONBITS-1:0] win_idx;
  logic                     hit_any;

  assign out_tag    = tags_q[LATENCY-1];
  assign issue      = (state_q == RUN) && proc_ready_i;
  assign last_round = ({1'b0, base_q} + {1'b0, STEP}) >= SPACE;

  // The final round may straddle the end of the nonce space; 33-bit sums keep
  // the comparison honest when NONCESPACE is 2^32.
  always_comb begin
    live_hits = '0;
    for (int i = 0; i < int'(NUMPROCESSORS); i++) begin
      live_hits[i] = out_tag.valid && success_i[i] &&
                     (({1'b0, out_tag.base} + 33'(i)) < SPACE);
    end
  end

  // Rounds still travelling towards the output stage.
  always_comb begin
    inflight = 1'b0;
    for (int k = 0; k < int'(LATENCY) - 1; k++) begin
      inflight = inflight | tags_q[k].valid;
    end
  end

  lowest_set_encoder #(
    .N(NUMPROCESSORS),
    .W(PARTITIONBITS)
  ) u_enc (
    .req(live_hits),
    .idx(win_idx),
    .any(hit_any)
  );

  always_comb begin
    state_d  = state_q;
    flush    = 1'b0;
    take_hit = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
      flush   = 1'b1;
    end else if (start_i) begin
      state_d = RUN;
      flush   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: ;
        RUN: begin
          if (hit_any) begin
            take_hit = 1'b1;
            state_d  = DONE;
          end else if (issue && last_round) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (hit_any) begin
            take_hit = 1'b1;
            state_d  = DONE;
          end else if (!inflight) begin
            state_d = DONE;
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      base_q  <= '0;
      first_q <= 1'b1;
      found_q <= 1'b0;
      nonce_q <= '0;
    end else begin
      if (issue) begin
        base_q  <= base_q + STEP;
        first_q <= 1'b0;
      end
      if (take_hit) begin
        found_q <= 1'b1;
        nonce_q <= out_tag.base + 32'(win_idx);
      end
    end
  end

  // Shifts every cycle so a round's tag lines up with its success vector.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int k = 0; k < int'(LATENCY); k++) tags_q[k] <= '0;
    end else begin
      tags_q[0] <= round_tag_t'{valid: issue, base: base_q};
      for (int k = 1; k < int'(LATENCY); k++) tags_q[k] <= tags_q[k-1];
    end
  end

`ifdef SEARCH_STATS_EN
  logic [31:0] rounds_q;

  always_ff @(posedge clk) begin
    if (rst || flush)  rounds_q <= '0;
    else if (issue)    rounds_q <= rounds_q + 32'd1;
  end

  assign rounds_o = rounds_q;
`endif

  assign round_valid_o = issue;
  assign round_first_o = issue && first_q;
  assign round_base_o  = base_q;
  assign busy_o        = (state_q == RUN) || (state_q == DRAIN);
  assign done_o        = (state_q == DONE);
  assign found_o       = found_q;
  assign nonce_o       = nonce_q;

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Two DUTs (NONCESPACE 100 and 95) share control inputs; each gets its own hash-array model and scoreboard.
module tb_nonce_search_ctrl;
  import miner_pkg::*;

  localparam int NP  = 10;
  localparam int LAT = 4;
  localparam int NI  = 2;

  typedef struct { nonce_t base; bit first; } exp_round_t;
  typedef struct { bit found; nonce_t nonce; nonce_t rbase; } exp_res_t;

  logic clk = 1'b0;
  logic rst, start_i, abort_i, proc_ready_i;

  logic [NP-1:0] success     [NI];
  logic          round_valid [NI];
  logic          round_first [NI];
  logic [31:0]   round_base  [NI];
  logic          busy        [NI];
  logic          done        [NI];
  logic          found       [NI];
  logic [31:0]   nonce       [NI];
`ifdef SEARCH_STATS_EN
  logic [31:0]   rounds      [NI];
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Golden nonces: the hash array reports a hit for nonce n when golden[g][n].
  bit         golden     [NI][128];
  exp_round_t exp_rounds [NI][$];
  exp_res_t   exp_res    [NI][$];

  // Monitor-owned state.
  logic [NP-1:0] pipe      [NI][LAT+1];
  bit            done_q    [NI];
  int            done_cnt  [NI];
  int            done_cyc  [NI];
  int            rbase_cyc [NI];

  // Stimulus-owned state.
  int     base_cnt  [NI];
  bit     exp_found [NI];
  nonce_t exp_nonce [NI];
  int     start_cyc;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    nonce_search_ctrl #(
      .NUMPROCESSORS(NP),
      .NONCESPACE(g == 0 ? 100 : 95),
      .LATENCY(LAT)
    ) dut (
      .clk(clk),
      .rst(rst),
      .start_i(start_i),
      .abort_i(abort_i),
      .proc_ready_i(proc_ready_i),
      .success_i(success[g]),
      .round_valid_o(round_valid[g]),
      .round_first_o(round_first[g]),
      .round_base_o(round_base[g]),
      .busy_o(busy[g]),
      .done_o(done[g]),
`ifdef SEARCH_STATS_EN
      .rounds_o(rounds[g]),
`endif
      .found_o(found[g]),
      .nonce_o(nonce[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int space_of(input int g);
    return (g == 0) ? 100 : 95;
  endfunction

  task automatic check(input string name, input int g, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d cycle %0d: got %0d, want %0d", name, g, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hash-array model plus scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      logic [NP-1:0] v;
      exp_round_t    er;
      exp_res_t      rr;
      v = NP'($urandom);
      if (!rst) begin
        if (round_valid[g]) begin
          if (exp_rounds[g].size() == 0) begin
            check("unexpected_issue", g, round_valid[g], 0);
          end else begin
            er = exp_rounds[g].pop_front();
            check("issue_base", g, round_base[g], er.base);
            check("issue_first", g, round_first[g], er.first);
          end
          if (exp_res[g].size() != 0 && round_base[g] == exp_res[g][0].rbase) rbase_cyc[g] = cyc;
          for (int i = 0; i < NP; i++) begin
            v[i] = (int'(round_base[g]) + i < 128) ? golden[g][int'(round_base[g]) + i] : 1'b0;
          end
        end
        if (done[g] && !done_q[g]) begin
          done_cnt[g]++;
          done_cyc[g] = cyc;
          check("busy_at_done", g, busy[g], 0);
          if (exp_res[g].size() == 0) begin
            check("unexpected_done", g, done[g], 0);
          end else begin
            rr = exp_res[g].pop_front();
            check("found", g, found[g], rr.found);
            if (rr.found) check("nonce", g, nonce[g], rr.nonce);
            check("done_latency", g, cyc, rbase_cyc[g] + LAT + 1);
          end
        end
      end
      done_q[g] = done[g];
      for (int k = LAT; k > 0; k--) pipe[g][k] = pipe[g][k-1];
      pipe[g][0] = v;
      success[g] = pipe[g][LAT];
    end
  end

  task automatic clear_golden();
    for (int g = 0; g < NI; g++)
      for (int n = 0; n < 128; n++) golden[g][n] = 1'b0;
  endtask

  // Reference model: bases 0, NP, ... up to the first base whose round reaches
  // the end of the space; the winner is simply the smallest golden nonce.
  task automatic start_search();
    for (int g = 0; g < NI; g++) begin
      int sp;
      int b;
      int w;
      sp = space_of(g);
      exp_rounds[g].delete();
      exp_res[g].delete();
      b = 0;
      while (1) begin
        exp_rounds[g].push_back('{base: nonce_t'(b), first: (b == 0)});
        if (b + NP >= sp) break;
        b += NP;
      end
      w = -1;
      for (int n = sp - 1; n >= 0; n--) if (golden[g][n]) w = n;
      exp_found[g] = (w >= 0);
      exp_nonce[g] = (w >= 0) ? nonce_t'(w) : '0;
      exp_res[g].push_back('{found: exp_found[g], nonce: exp_nonce[g],
                             rbase: nonce_t'((w >= 0) ? (w - w % NP) : b)});
      base_cnt[g] = done_cnt[g];
    end
    start_cyc    = cyc;
    start_i      = 1'b1;
    abort_i      = 1'b0;
    proc_ready_i = 1'b0;
    tick();
    start_i = 1'b0;
  endtask

  // mode 0: always ready; 1: random ready; 2: stall 3 cycles after base 30.
  task automatic run_search(input int mode, input int budget);
    for (int k = 1; k <= budget; k++) begin
      if (done_cnt[0] != base_cnt[0] && done_cnt[1] != base_cnt[1]) break;
      case (mode)
        0:       proc_ready_i = 1'b1;
        1:       proc_ready_i = ($urandom_range(0, 3) != 0);
        default: proc_ready_i = !(k >= 5 && k <= 7);
      endcase
      tick();
    end
    for (int g = 0; g < NI; g++)
      if (done_cnt[g] == base_cnt[g]) check("done_timeout", g, done[g], 1);
    for (int k = 0; k < LAT + 2; k++) begin
      proc_ready_i = 1'($urandom_range(0, 1));
      tick();
    end
    for (int g = 0; g < NI; g++) begin
      check("done_held", g, done[g], 1);
      check("found_held", g, found[g], exp_found[g]);
      if (exp_found[g]) check("nonce_held", g, nonce[g], exp_nonce[g]);
    end
  endtask

  initial begin
    rst          = 1'b1;
    start_i      = 1'b1;
    abort_i      = 1'b0;
    proc_ready_i = 1'b1;
    clear_golden();
    tick();
    tick();
    for (int g = 0; g < NI; g++) begin
      check("rst_round_valid", g, round_valid[g], 0);
      check("rst_round_first", g, round_first[g], 0);
      check("rst_round_base", g, round_base[g], 0);
      check("rst_busy", g, busy[g], 0);
      check("rst_done", g, done[g], 0);
      check("rst_found", g, found[g], 0);
      check("rst_nonce", g, nonce[g], 0);
    end
    rst          = 1'b0;
    start_i      = 1'b0;
    proc_ready_i = 1'b0;
    tick();

    // Exhaustion: issues on start+1..start+10, done at start+15.
    clear_golden();
    start_search();
    run_search(0, 200);
    for (int g = 0; g < NI; g++) check("exhaust_done_cycle", g, done_cyc[g], start_cyc + 15);

    // Priority: bits 3 and 7 of base 20, plus later hits that must not win.
    clear_golden();
    for (int g = 0; g < NI; g++) begin
      golden[g][23] = 1'b1;
      golden[g][27] = 1'b1;
      golden[g][45] = 1'b1;
      golden[g][81] = 1'b1;
    end
    start_search();
    run_search(1, 200);

    // Final-round mask: 96 lies outside the 95-nonce space, 94 does not.
    clear_golden();
    for (int g = 0; g < NI; g++) golden[g][96] = 1'b1;
    start_search();
    run_search(0, 200);
    clear_golden();
    for (int g = 0; g < NI; g++) golden[g][94] = 1'b1;
    start_search();
    run_search(1, 200);

    // Backpressure straddling the rounds that hold the hits.
    clear_golden();
    golden[0][37] = 1'b1;
    golden[1][46] = 1'b1;
    start_search();
    run_search(2, 200);

    // Abort just after base 50 issues, restart at once; stale hits still in flight.
    clear_golden();
    for (int g = 0; g < NI; g++) begin
      golden[g][45] = 1'b1;
      golden[g][55] = 1'b1;
    end
    start_search();
    for (int k = 1; k <= 6; k++) begin
      proc_ready_i = 1'b1;
      tick();
    end
    abort_i      = 1'b1;
    proc_ready_i = 1'b0;
    for (int g = 0; g < NI; g++) begin
      exp_rounds[g].delete();
      exp_res[g].delete();
    end
    tick();
    abort_i = 1'b0;
    clear_golden();
    for (int g = 0; g < NI; g++) golden[g][88] = 1'b1;
    start_search();
    run_search(0, 200);

    // abort_i and start_i together: abort wins, nothing issues afterwards.
    abort_i      = 1'b1;
    start_i      = 1'b1;
    proc_ready_i = 1'b0;
    for (int g = 0; g < NI; g++) begin
      exp_rounds[g].delete();
      exp_res[g].delete();
    end
    tick();
    abort_i = 1'b0;
    start_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      proc_ready_i = 1'b1;
      tick();
    end
    for (int g = 0; g < NI; g++) begin
      check("abort_wins_done", g, done[g], 0);
      check("abort_wins_busy", g, busy[g], 0);
      check("abort_clears_found", g, found[g], 0);
      check("abort_clears_nonce", g, nonce[g], 0);
    end

    // Random golden sets with random backpressure.
    for (int s = 0; s < 12; s++) begin
      clear_golden();
      for (int g = 0; g < NI; g++)
        for (int n = 0; n < 100; n++) golden[g][n] = ($urandom_range(0, 59) == 0);
      start_search();
      run_search(1, 200);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
